// File: rtl/apb_ccp_filter.sv
// APB-programmable digital glitch filter that conditions an asynchronous CCP pad
// signal for a timer; includes prescaled sampling, edge counting and status interrupts.
module apb_ccp_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FLT_W       = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PIRQ,
  input  logic        CCP_IN,
  output logic        CCP_OUT
);

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_FLT    = 5'd1;
  localparam logic [4:0] A_PRE    = 5'd2;
  localparam logic [4:0] A_LEVEL  = 5'd3;
  localparam logic [4:0] A_ECNT   = 5'd4;
  localparam logic [4:0] A_STATUS = 5'd5;
  localparam logic [4:0] A_IM     = 5'd6;
  localparam logic [4:0] A_IC     = 5'd7;

  logic [1:0]             r_ctrl;
  logic [FLT_W-1:0]       r_flt;
  logic [15:0]            r_pre;
  logic [2:0]             r_im;
  logic [3:0]             r_ic;
  logic [2:0]             r_status;
  logic [15:0]            r_ecnt;
  logic [15:0]            r_pcnt;
  logic [FLT_W-1:0]       r_scnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ccp_out;

  logic [4:0]       w_idx;
  logic             w_wr;
  logic             w_en;
  logic             w_sample;
  logic             w_tick;
  logic             w_inc;
  logic [2:0]       w_set;
  logic [FLT_W-1:0] w_scnt_nxt;
  logic             w_out_nxt;
  logic             w_unused_bits;

  assign w_idx         = PADDR[7:3];
  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_en          = r_ctrl[0];
  assign w_sample      = r_sync[SYNC_STAGES-1] ^ r_ctrl[1];
  assign w_tick        = w_en & (r_pcnt == r_pre);
  assign w_unused_bits = ^{PADDR[31:8], PADDR[2:0], PWDATA[31:16]};

  assign PREADY  = 1'b1;
  assign PIRQ    = |(r_im & r_status);
  assign CCP_OUT = r_ccp_out;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl <= '0;
      r_flt  <= '0;
      r_pre  <= '0;
      r_im   <= '0;
      r_ic   <= '0;
    end else begin
      r_ic <= (w_wr && w_idx == A_IC) ? PWDATA[3:0] : 4'd0;
      if (w_wr) begin
        case (w_idx)
          A_CTRL:  r_ctrl <= PWDATA[1:0];
          A_FLT:   r_flt  <= PWDATA[FLT_W-1:0];
          A_PRE:   r_pre  <= PWDATA[15:0];
          A_IM:    r_im   <= PWDATA[2:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync <= '0;
      r_pcnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], CCP_IN};
      if (!w_en || (w_wr && w_idx == A_PRE) || w_tick)
        r_pcnt <= '0;
      else
        r_pcnt <= r_pcnt + 16'd1;
    end
  end

  // Disabled: track the sample directly so enabling never sees a stale level.
  always_comb begin
    w_inc      = 1'b0;
    w_set      = 3'b000;
    w_scnt_nxt = r_scnt;
    w_out_nxt  = r_ccp_out;
    if (!w_en) begin
      w_out_nxt  = w_sample;
      w_scnt_nxt = '0;
    end else if (w_tick) begin
      if (w_sample != r_ccp_out) begin
        if (r_scnt >= r_flt) begin
          w_out_nxt  = w_sample;
          w_scnt_nxt = '0;
          w_inc      = 1'b1;
          w_set      = w_sample ? 3'b001 : 3'b010;
        end else begin
          w_scnt_nxt = r_scnt + 1'b1;
        end
      end else if (r_scnt != '0) begin
        w_scnt_nxt = '0;
        w_set      = 3'b100;
      end
    end
    if (w_wr && w_idx == A_FLT)
      w_scnt_nxt = '0;
  end

  // Sets win over same-cycle clears; a counted edge coinciding with a clear yields 1.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_scnt    <= '0;
      r_ccp_out <= 1'b0;
      r_status  <= '0;
      r_ecnt    <= '0;
    end else begin
      r_scnt    <= w_scnt_nxt;
      r_ccp_out <= w_out_nxt;
      r_status  <= (r_status & ~r_ic[2:0]) | w_set;
      if (w_inc)
        r_ecnt <= r_ic[3] ? 16'd1 : r_ecnt + 16'd1;
      else if (r_ic[3])
        r_ecnt <= '0;
    end
  end

  always_comb begin
    PRDATA = 32'hDEAD_BEEF;
    case (w_idx)
      A_CTRL:   PRDATA = {30'd0, r_ctrl};
      A_FLT: begin
        PRDATA = 32'd0;
        PRDATA[FLT_W-1:0] = r_flt;
      end
      A_PRE:    PRDATA = {16'd0, r_pre};
      A_LEVEL:  PRDATA = {31'd0, r_ccp_out};
      A_ECNT:   PRDATA = {16'd0, r_ecnt};
      A_STATUS: PRDATA = {29'd0, r_status};
      A_IM:     PRDATA = {29'd0, r_im};
      A_IC:     PRDATA = 32'd0;
      default:  PRDATA = 32'hDEAD_BEEF;
    endcase
  end

endmodule

// File: tb/tb_apb_ccp_filter.sv
// Directed bench for apb_ccp_filter: filter latency, glitch rejection, prescaler,
// enable/invert, counter wrap and set/clear collisions, reset and address decode.
module tb_apb_ccp_filter;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_FLT    = 32'h08;
  localparam logic [31:0] A_PRE    = 32'h10;
  localparam logic [31:0] A_LEVEL  = 32'h18;
  localparam logic [31:0] A_ECNT   = 32'h20;
  localparam logic [31:0] A_STATUS = 32'h28;
  localparam logic [31:0] A_IM     = 32'h30;
  localparam logic [31:0] A_IC     = 32'h38;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PIRQ;
  logic        CCP_IN;
  logic        CCP_OUT;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  apb_ccp_filter dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PIRQ    (PIRQ),
    .CCP_IN  (CCP_IN),
    .CCP_OUT (CCP_OUT)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic do_reset();
    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; CCP_IN = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  // Commit lands on the third rising edge after the call; optionally changes the pad at setup.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                        input bit chg_pin = 1'b0, input bit pin = 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    if (chg_pin) CCP_IN = pin;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (CCP_OUT !== 1'b0) begin failures++; $display("FAIL rst_ccp_out: got %0h exp 0", CCP_OUT); end
    checks++; if (PIRQ !== 1'b0) begin failures++; $display("FAIL rst_pirq: got %0h exp 0", PIRQ); end
    checks++; if (PREADY !== 1'b1) begin failures++; $display("FAIL rst_pready: got %0h exp 1", PREADY); end
    apb_rd(A_CTRL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_ctrl: got %h exp 0", rd); end
    apb_rd(A_FLT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_flt: got %h exp 0", rd); end
    apb_rd(A_PRE, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_pre: got %h exp 0", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_ecnt: got %h exp 0", rd); end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_status: got %h exp 0", rd); end
    apb_rd(A_IM, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_im: got %h exp 0", rd); end
  endtask

  task automatic test_latency();
    do_reset();
    apb_wr(A_FLT, 32'd3);
    apb_wr(A_CTRL, 32'h1);
    apb_rd(A_FLT, rd);
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL lat_flt_rb: got %h exp 3", rd); end
    @(posedge PCLK); #1;
    CCP_IN = 1'b1;
    // 2 sync flops + 3 stability ticks + 1 accept tick
    for (int i = 1; i <= 6; i++) begin
      @(posedge PCLK); #1;
      checks++; if (CCP_OUT !== (i == 6)) begin failures++; $display("FAIL lat_edge%0d: got %0h exp %0h", i, CCP_OUT, (i == 6)); end
    end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL lat_status: got %h exp 1", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL lat_ecnt: got %h exp 1", rd); end
    apb_wr(A_IC, 32'h9);
    @(posedge PCLK); #1;
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL lat_ic_status: got %h exp 0", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL lat_ic_ecnt: got %h exp 0", rd); end
  endtask

  task automatic test_glitch();
    do_reset();
    apb_wr(A_FLT, 32'd3);
    apb_wr(A_IM, 32'h4);
    apb_wr(A_CTRL, 32'h1);
    CCP_IN = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 CCP_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      checks++; if (CCP_OUT !== 1'b0) begin failures++; $display("FAIL gl_out%0d: got %0h exp 0", i, CCP_OUT); end
    end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL gl_status: got %h exp 4", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL gl_ecnt: got %h exp 0", rd); end
    checks++; if (PIRQ !== 1'b1) begin failures++; $display("FAIL gl_pirq_set: got %0h exp 1", PIRQ); end
    apb_wr(A_IC, 32'h4);
    checks++; if (PIRQ !== 1'b1) begin failures++; $display("FAIL gl_pirq_hold: got %0h exp 1", PIRQ); end
    @(posedge PCLK); #1;
    checks++; if (PIRQ !== 1'b0) begin failures++; $display("FAIL gl_pirq_clr: got %0h exp 0", PIRQ); end
  endtask

  task automatic test_prescaler();
    do_reset();
    apb_wr(A_FLT, 32'd1);
    apb_wr(A_PRE, 32'd4);
    apb_wr(A_CTRL, 32'h1);
    // Ticks 5 and 10 edges after enable; the pad is synchronized before the first.
    CCP_IN = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(posedge PCLK); #1;
      checks++; if (CCP_OUT !== (i >= 10)) begin failures++; $display("FAIL pre_edge%0d: got %0h exp %0h", i, CCP_OUT, (i >= 10)); end
    end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL pre_ecnt: got %h exp 1", rd); end
  endtask

  task automatic test_enable_invert();
    do_reset();
    apb_wr(A_CTRL, 32'h2);
    @(posedge PCLK); #1;
    checks++; if (CCP_OUT !== 1'b1) begin failures++; $display("FAIL inv_out: got %0h exp 1", CCP_OUT); end
    apb_rd(A_LEVEL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL inv_level: got %h exp 1", rd); end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL inv_status: got %h exp 0", rd); end
    apb_wr(A_CTRL, 32'h3);
    repeat (4) @(posedge PCLK);
    #1;
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL en_status: got %h exp 0", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL en_ecnt: got %h exp 0", rd); end
    apb_wr(A_CTRL, 32'h1);
    @(posedge PCLK); #1;
    checks++; if (CCP_OUT !== 1'b0) begin failures++; $display("FAIL invtog_out: got %0h exp 0", CCP_OUT); end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL invtog_status: got %h exp 2", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL invtog_ecnt: got %h exp 1", rd); end
  endtask

  task automatic test_collision_wrap();
    do_reset();
    apb_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 65535; i++) begin
      CCP_IN = ~CCP_IN;
      @(posedge PCLK); #1;
    end
    repeat (4) @(posedge PCLK);
    #1;
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'hFFFF) begin failures++; $display("FAIL wrap_ffff: got %h exp ffff", rd); end
    CCP_IN = ~CCP_IN;
    repeat (4) @(posedge PCLK);
    #1;
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h exp 0", rd); end
    apb_wr(A_IC, 32'h7);
    @(posedge PCLK); #1;
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL col_pre_status: got %h exp 0", rd); end
    apb_wr(A_IC, 32'h1, 1'b1, 1'b1);
    @(posedge PCLK); #1;
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL col_risef: got %h exp 1", rd); end
    apb_wr(A_IC, 32'h8, 1'b1, 1'b0);
    @(posedge PCLK); #1;
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL col_ecnt: got %h exp 1", rd); end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL col_status: got %h exp 3", rd); end
  endtask

  task automatic test_reset_decode();
    do_reset();
    apb_wr(A_FLT, 32'd3);
    apb_wr(A_CTRL, 32'h1);
    CCP_IN = 1'b1;
    repeat (4) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    checks++; if (CCP_OUT !== 1'b0) begin failures++; $display("FAIL mid_rst_out: got %0h exp 0", CCP_OUT); end
    apb_rd(A_CTRL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_ctrl: got %h exp 0", rd); end
    apb_rd(A_FLT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_flt: got %h exp 0", rd); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (5) @(posedge PCLK);
    #1;
    checks++; if (CCP_OUT !== 1'b1) begin failures++; $display("FAIL post_rst_out: got %0h exp 1", CCP_OUT); end
    apb_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_rst_status: got %h exp 0", rd); end
    apb_rd(A_ECNT, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_rst_ecnt: got %h exp 0", rd); end
    apb_rd(32'h40, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dec_40: got %h exp deadbeef", rd); end
    apb_rd(32'hF8, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dec_f8: got %h exp deadbeef", rd); end
    apb_rd(32'h1C, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL dec_alias_level: got %h exp 1", rd); end
    apb_wr(A_LEVEL, 32'h0);
    apb_rd(A_LEVEL, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ro_write_level: got %h exp 1", rd); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_prescaler();
    test_enable_invert();
    test_collision_wrap();
    test_reset_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_ccp_filter.md
APB_CCP_FILTER -- requirements
Module: apb_ccp_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter FLT_W, default 8, meaning the width of the filter-length register.
REQ-003 SHALL have port PCLK, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port PRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PSEL, input, 1 bit: APB select.
REQ-006 SHALL have port PENABLE, input, 1 bit: APB access phase.
REQ-007 SHALL have port PWRITE, input, 1 bit: APB write.
REQ-008 SHALL have port PADDR, input, 32 bits: APB address; only PADDR[7:3] is decoded, registers sit 8 bytes apart.
REQ-009 SHALL have port PWDATA, input, 32 bits: APB write data.
REQ-010 SHALL have port PRDATA, output, 32 bits: APB read data, combinational.
REQ-011 SHALL have port PREADY, output, 1 bit: tied to 1, zero wait states.
REQ-012 SHALL have port PIRQ, output, 1 bit: the OR over (IM & STATUS).
REQ-013 SHALL have port CCP_IN, input, 1 bit: the raw asynchronous pad signal.
REQ-014 SHALL have port CCP_OUT, output, 1 bit: the filtered level, registered, driving the timer's CCP input.

Function
REQ-015 SHALL provide these registers:
- 0x00 CTRL RW [1:0]: 0 EN, 1 INV.
- 0x08 FLT RW [FLT_W-1:0].
- 0x10 PRE RW [15:0].
- 0x18 LEVEL R [0] = CCP_OUT.
- 0x20 ECNT R [15:0].
- 0x28 STATUS R [2:0]: 0 RISEF, 1 FALLF, 2 GLF.
- 0x30 IM RW [2:0].
- 0x38 IC W [3:0].
Unused bits read 0; unmapped offsets read 32'hDEAD_BEEF.
REQ-016 SHALL commit a write on the cycle where PSEL & PENABLE & PWRITE are all high; writes to read-only offsets are ignored.
REQ-017 SHALL treat IC as a self-clearing pulse register: a written value is held one cycle, then returns to 0.
- IC[2:0] clears the matching STATUS bits.
- IC[3] clears ECNT.
REQ-018 SHALL pass CCP_IN through SYNC_STAGES flops; the sample is the last flop XOR INV.
REQ-019 SHALL run a 16-bit prescale counter PCNT from 0 to PRE, asserting a one-cycle TICK when PCNT == PRE and then wrapping to 0.
- PRE = 0 gives a tick every cycle.
- Any write to PRE forces PCNT to 0.
REQ-020 SHALL, while EN = 0:
- hold PCNT and the stability counter SCNT at 0;
- load CCP_OUT with the sample every cycle, setting no flags and leaving ECNT unchanged;
- so that enabling never produces a spurious edge.
REQ-021 SHALL, on each TICK with EN = 1, evaluate the sample against CCP_OUT:
- Sample differs and SCNT == FLT: set CCP_OUT to the sample, set SCNT to 0, increment ECNT (16-bit, wraps FFFF to 0000), and set RISEF on a 0->1 change or FALLF on a 1->0 change.
- Sample differs and SCNT < FLT: increment SCNT.
- Sample equals CCP_OUT and SCNT != 0: set SCNT to 0 and set GLF (rejected glitch).
- Sample equals CCP_OUT and SCNT == 0: no change.
REQ-022 SHALL make FLT = 0 accept every mismatch on the first tick, so no glitch is ever flagged.
REQ-023 SHALL take no action on non-TICK cycles; SCNT and CCP_OUT hold.
REQ-024 SHALL, with PRE = 0 and EN = 1, change CCP_OUT exactly SYNC_STAGES + FLT + 1 PCLK edges after a stable CCP_IN change that meets setup before an edge.
REQ-025 SHALL give set priority over clear when a STATUS set and an IC clear land in the same cycle.
REQ-026 SHALL give increment priority over clear when an ECNT increment and IC[3] land in the same cycle, so ECNT becomes 1.
REQ-027 SHALL reset SCNT to 0 on a write to FLT; CCP_OUT is unaffected.
REQ-028 SHALL let a write toggling INV while EN = 1 be processed as a normal input change through the filter.

Reset
REQ-029 SHALL, on PRESETn low, asynchronously clear to 0: all registers, the synchronizer flops, PCNT, SCNT, ECNT, STATUS, IC, CCP_OUT and PIRQ.
REQ-030 SHALL, when reset asserts mid-filter, discard the pending SCNT; after release the block behaves as freshly reset.

Verification
REQ-031 SHALL cover filter latency: EN = 1, PRE = 0, FLT = 3, CCP_IN 0->1 held -> CCP_OUT rises 6 cycles later; RISEF = 1; ECNT = 1.
REQ-032 SHALL cover glitch rejection: FLT = 3, PRE = 0, a 2-cycle high pulse on CCP_IN -> CCP_OUT stays 0; GLF = 1; ECNT = 0; with IM = 3'b100, PIRQ = 1 until IC = 3'b100 is written.
REQ-033 SHALL cover the prescaler: PRE = 4, FLT = 1, CCP_IN held high -> CCP_OUT rises on the 2nd TICK after the synchronized change, and TICK spacing is 5 cycles.
REQ-034 SHALL cover enable and invert: EN = 0, INV = 1, CCP_IN = 0 -> CCP_OUT = 1 with no flags; then EN = 1 -> no RISEF/FALLF; ECNT = 0.
REQ-035 SHALL cover the collision and wrap case: ECNT forced to FFFF by edges, one more edge -> 0000; an edge coinciding with an IC = 4'b0001 write leaves RISEF = 1.
REQ-036 SHALL cover reset and decode: reset asserted while SCNT = 2 -> all registers 0 and CCP_OUT = 0; a read at offset 0x40 -> 32'hDEAD_BEEF.
